// File: rtl/uart_frame_parser.sv
// Delineates SOF/CMD/ADDR/LEN/DATA/CRC command frames from the UART RX byte stream,
// checks the trailing CRC8 via the shared engine and holds validated frames for the AXI front-end.
module uart_frame_parser #(
    parameter int          MAX_PAYLOAD    = 16,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    localparam int         LEN_W          = $clog2(MAX_PAYLOAD + 1),
    localparam int         IDX_W          = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              crc_enable,
    output logic [7:0]        crc_data,
    output logic              crc_reset,
    input  logic [7:0]        crc_value,
    output logic              frame_valid,
    output logic [7:0]        frame_cmd,
    output logic [31:0]       frame_addr,
    output logic [LEN_W-1:0]  frame_len,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [7:0]        rd_data,
    input  logic              frame_ack,
    output logic              crc_err,
    output logic              len_err,
    output logic              timeout_err
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CRC,
        S_READY
    } state_t;

    state_t            state_q;
    logic [7:0]        cmd_q;
    logic [31:0]       addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  data_cnt_q;
    logic [1:0]        addr_cnt_q;
    logic [TO_W-1:0]   idle_cnt_q;

    logic              rx_ready_q;
    logic              frame_valid_q;
    logic [7:0]        frame_cmd_q;
    logic [31:0]       frame_addr_q;
    logic [LEN_W-1:0]  frame_len_q;
    logic              crc_err_q;
    logic              len_err_q;
    logic              timeout_err_q;

    logic [7:0]        payload_mem [0:DEPTH-1];

    logic              accept;
    logic              in_frame;
    logic              folding;
    logic              sof_seen;
    logic              len_bad;
    logic              crc_check;
    logic              timeout_hit;
    logic [LEN_W-1:0]  data_cnt_d;

    assign accept     = rx_valid && rx_ready_q;
    assign in_frame   = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_LEN) ||
                        (state_q == S_DATA) || (state_q == S_CRC);
    assign folding    = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_LEN) ||
                        (state_q == S_DATA);
    assign sof_seen   = (state_q == S_IDLE) && accept && (rx_data == SOF_BYTE);
    assign len_bad    = (state_q == S_LEN) && accept && (rx_data > 8'(MAX_PAYLOAD));
    assign crc_check  = (state_q == S_CRC) && accept;
    // An accepted byte always beats an expiring idle counter.
    assign timeout_hit = in_frame && !accept && (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign data_cnt_d  = data_cnt_q + LEN_W'(1);

    // The CRC engine is driven combinationally so it folds the byte on the accepting edge.
    assign crc_enable = folding && accept;
    assign crc_data   = rx_data;
    assign crc_reset  = sof_seen || len_bad || crc_check || timeout_hit;

    assign rx_ready    = rx_ready_q;
    assign frame_valid = frame_valid_q;
    assign frame_cmd   = frame_cmd_q;
    assign frame_addr  = frame_addr_q;
    assign frame_len   = frame_len_q;
    assign crc_err     = crc_err_q;
    assign len_err     = len_err_q;
    assign timeout_err = timeout_err_q;
    assign rd_data     = frame_valid_q ? payload_mem[rd_idx] : 8'h00;

    always_ff @(posedge clk) begin
        if ((state_q == S_DATA) && accept) begin
            payload_mem[data_cnt_q[IDX_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cmd_q         <= 8'h00;
            addr_q        <= 32'h0;
            len_q         <= '0;
            data_cnt_q    <= '0;
            addr_cnt_q    <= 2'd0;
            idle_cnt_q    <= '0;
            rx_ready_q    <= 1'b1;
            frame_valid_q <= 1'b0;
            frame_cmd_q   <= 8'h00;
            frame_addr_q  <= 32'h0;
            frame_len_q   <= '0;
            crc_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            crc_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;

            if (!in_frame || accept) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + TO_W'(1);
            end

            if (timeout_hit) begin
                state_q       <= S_IDLE;
                timeout_err_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (sof_seen) begin
                            state_q <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (accept) begin
                            cmd_q      <= rx_data;
                            addr_cnt_q <= 2'd0;
                            state_q    <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (accept) begin
                            addr_q[{addr_cnt_q, 3'b000} +: 8] <= rx_data;
                            addr_cnt_q <= addr_cnt_q + 2'd1;
                            if (addr_cnt_q == 2'd3) begin
                                state_q <= S_LEN;
                            end
                        end
                    end
                    S_LEN: begin
                        if (len_bad) begin
                            len_err_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else if (accept) begin
                            len_q      <= rx_data[LEN_W-1:0];
                            data_cnt_q <= '0;
                            state_q    <= (rx_data == 8'h00) ? S_CRC : S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            data_cnt_q <= data_cnt_d;
                            if (data_cnt_d == len_q) begin
                                state_q <= S_CRC;
                            end
                        end
                    end
                    S_CRC: begin
                        // Output frame registers only change on a CRC match.
                        if (crc_check) begin
                            if (rx_data == crc_value) begin
                                frame_cmd_q   <= cmd_q;
                                frame_addr_q  <= addr_q;
                                frame_len_q   <= len_q;
                                frame_valid_q <= 1'b1;
                                rx_ready_q    <= 1'b0;
                                state_q       <= S_READY;
                            end else begin
                                crc_err_q <= 1'b1;
                                state_q   <= S_IDLE;
                            end
                        end
                    end
                    S_READY: begin
                        if (frame_ack) begin
                            frame_valid_q <= 1'b0;
                            rx_ready_q    <= 1'b1;
                            state_q       <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: a CRC8 engine model plus a frame-level reference that parses
// each transmitted byte list and predicts the decoded frame or the error pulse.
module tb_uart_frame_parser;

    localparam int         MAXP  = 16;
    localparam int         TOC   = 16;
    localparam logic [7:0] SOF   = 8'hA5;
    localparam int         LEN_W = $clog2(MAXP + 1);
    localparam int         IDX_W = $clog2(MAXP);

    localparam int K_NONE = 0;
    localparam int K_OK   = 1;
    localparam int K_CRC  = 2;
    localparam int K_LEN  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              crc_enable;
    logic [7:0]        crc_data;
    logic              crc_reset;
    logic [7:0]        crc_value;
    logic              frame_valid;
    logic [7:0]        frame_cmd;
    logic [31:0]       frame_addr;
    logic [LEN_W-1:0]  frame_len;
    logic [IDX_W-1:0]  rd_idx;
    logic [7:0]        rd_data;
    logic              frame_ack;
    logic              crc_err;
    logic              len_err;
    logic              timeout_err;

    uart_frame_parser #(
        .MAX_PAYLOAD    (MAXP),
        .TIMEOUT_CYCLES (TOC),
        .SOF_BYTE       (SOF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .crc_enable  (crc_enable),
        .crc_data    (crc_data),
        .crc_reset   (crc_reset),
        .crc_value   (crc_value),
        .frame_valid (frame_valid),
        .frame_cmd   (frame_cmd),
        .frame_addr  (frame_addr),
        .frame_len   (frame_len),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .frame_ack   (frame_ack),
        .crc_err     (crc_err),
        .len_err     (len_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // CRC8, poly 0x07, init 0, MSB first
    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int k = 0; k < 8; k++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    // Shared CRC engine model
    logic [7:0] crc_reg;
    always @(posedge clk) begin
        if (rst || crc_reset) crc_reg <= 8'h00;
        else if (crc_enable)  crc_reg <= crc8_byte(crc_reg, crc_data);
    end
    assign crc_value = crc_enable ? crc8_byte(crc_reg, crc_data) : crc_reg;

    // Pulse monitor
    int   n_crc = 0, n_len = 0, n_to = 0, n_multi = 0, n_wide = 0;
    logic p_crc = 1'b0, p_len = 1'b0, p_to = 1'b0;
    always @(posedge clk) begin
        if (crc_err)     n_crc++;
        if (len_err)     n_len++;
        if (timeout_err) n_to++;
        if ($countones({crc_err, len_err, timeout_err}) > 1) n_multi++;
        if ((crc_err && p_crc) || (len_err && p_len) || (timeout_err && p_to)) n_wide++;
        p_crc = crc_err;
        p_len = len_err;
        p_to  = timeout_err;
    end

    // Reference model
    logic [7:0]  tx_q[$];
    int          exp_kind;
    logic [7:0]  exp_cmd;
    logic [31:0] exp_addr;
    int          exp_len;
    logic [7:0]  exp_data [0:255];

    task automatic model_frame();
        int i;
        logic [7:0] c;
        i = 0;
        exp_kind = K_NONE;
        while (i < tx_q.size() && tx_q[i] != SOF) i++;
        if (i + 7 > tx_q.size()) return;
        exp_cmd  = tx_q[i+1];
        exp_addr = {tx_q[i+5], tx_q[i+4], tx_q[i+3], tx_q[i+2]};
        exp_len  = int'(tx_q[i+6]);
        if (exp_len > MAXP) begin
            exp_kind = K_LEN;
            return;
        end
        c = 8'h00;
        for (int k = i + 1; k <= i + 6 + exp_len; k++) c = crc8_byte(c, tx_q[k]);
        for (int k = 0; k < exp_len; k++) exp_data[k] = tx_q[i+7+k];
        exp_kind = (tx_q[i+7+exp_len] == c) ? K_OK : K_CRC;
    endtask

    task automatic build_frame(input int njunk, input logic [7:0] cmd, input logic [31:0] addr,
                               input int len, input bit incr, input bit corrupt, input bit hdr_only);
        logic [7:0] c, b;
        tx_q.delete();
        for (int k = 0; k < njunk; k++) begin
            b = 8'($urandom_range(0, 255));
            if (b == SOF) b = 8'h5A;
            tx_q.push_back(b);
        end
        tx_q.push_back(SOF);
        tx_q.push_back(cmd);
        for (int k = 0; k < 4; k++) tx_q.push_back(addr[8*k +: 8]);
        tx_q.push_back(8'(len));
        if (hdr_only) return;
        c = 8'h00;
        c = crc8_byte(c, cmd);
        for (int k = 0; k < 4; k++) c = crc8_byte(c, addr[8*k +: 8]);
        c = crc8_byte(c, 8'(len));
        for (int k = 0; k < len; k++) begin
            b = incr ? 8'(k) : 8'($urandom_range(0, 255));
            tx_q.push_back(b);
            c = crc8_byte(c, b);
        end
        if (corrupt) c = c ^ 8'($urandom_range(1, 255));
        tx_q.push_back(c);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!rx_ready) begin
            chk("rx_ready_wait", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag);
        int c0, l0, t0;
        c0 = n_crc; l0 = n_len; t0 = n_to;
        model_frame();
        foreach (tx_q[i]) send_byte(tx_q[i]);
        repeat (2) begin @(posedge clk); #1; end
        $display("frame %s: bytes=%0d kind=%0d len=%0d valid=%0b", tag, tx_q.size(), exp_kind, exp_len, frame_valid);
        chk({tag, ".crc_err"},     32'(n_crc - c0), 32'(exp_kind == K_CRC));
        chk({tag, ".len_err"},     32'(n_len - l0), 32'(exp_kind == K_LEN));
        chk({tag, ".timeout_err"}, 32'(n_to - t0),  32'd0);
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(exp_kind == K_OK));
        if (exp_kind == K_OK) begin
            rx_valid = 1'b1;
            rx_data  = SOF;
            repeat (3) begin @(posedge clk); #1; end
            rx_valid = 1'b0;
            chk({tag, ".hold_valid"}, 32'(frame_valid), 32'd1);
            chk({tag, ".rx_ready"},   32'(rx_ready),    32'd0);
            chk({tag, ".cmd"},        32'(frame_cmd),   32'(exp_cmd));
            chk({tag, ".addr"},       frame_addr,       exp_addr);
            chk({tag, ".len"},        32'(frame_len),   32'(exp_len));
            for (int k = 0; k < exp_len; k++) begin
                rd_idx = IDX_W'(k);
                #1;
                chk($sformatf("%s.data%0d", tag, k), 32'(rd_data), 32'(exp_data[k]));
            end
            frame_ack = 1'b1;
            @(posedge clk); #1;
            frame_ack = 1'b0;
            chk({tag, ".ack_valid"}, 32'(frame_valid), 32'd0);
            chk({tag, ".ack_ready"}, 32'(rx_ready),    32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c0, l0;
        int len, mode;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rd_idx = '0; frame_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.rx_ready",    32'(rx_ready),    32'd1);
        chk("reset.frame_valid", 32'(frame_valid), 32'd0);
        chk("reset.frame_cmd",   32'(frame_cmd),   32'd0);
        chk("reset.frame_addr",  frame_addr,       32'd0);
        chk("reset.frame_len",   32'(frame_len),   32'd0);
        chk("reset.rd_data",     32'(rd_data),     32'd0);
        chk("reset.errs",        32'({crc_err, len_err, timeout_err}), 32'd0);
        chk("reset.crc_ctl",     32'({crc_enable, crc_reset}), 32'd0);
        rst = 1'b0;
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;

        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h4E};
        run_frame("len0_good");
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h4F};
        run_frame("len0_badcrc");
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h4E};
        run_frame("len0_again");

        build_frame(0, 8'h22, 32'hDEAD_BEEF, MAXP, 1'b1, 1'b0, 1'b0);
        run_frame("len_max");
        build_frame(0, 8'h23, 32'h0000_0040, MAXP + 1, 1'b0, 1'b0, 1'b1);
        run_frame("len_over");
        build_frame(0, 8'h24, 32'h1234_5678, 3, 1'b0, 1'b0, 1'b0);
        run_frame("after_len_err");

        build_frame(0, 8'h30, 32'hCAFE_0001, 5, 1'b0, 1'b0, 1'b0);
        tx_q.push_front(8'h5A);
        tx_q.push_front(8'hFF);
        tx_q.push_front(8'h00);
        run_frame("junk_prefix");

        // Inter-byte timeout: a byte on the 15th idle cycle survives, 16 idle cycles expire.
        t0 = n_to;
        send_byte(SOF);
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (14) @(posedge clk);
        #1;
        send_byte(8'h10);
        chk("to.byte_at_15", 32'(n_to - t0), 32'd0);
        repeat (15) begin @(posedge clk); #1; end
        chk("to.before_16", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        chk("to.at_16", 32'(timeout_err), 32'd1);
        @(posedge clk); #1;
        chk("to.one_cycle", 32'(timeout_err), 32'd0);
        chk("to.count", 32'(n_to - t0), 32'd1);
        $display("frame timeout: stalled after ADDR1");
        build_frame(0, 8'h41, 32'h0000_2000, 2, 1'b0, 1'b0, 1'b0);
        run_frame("after_timeout");

        // Reset in the middle of the payload
        c0 = n_crc; l0 = n_len; t0 = n_to;
        build_frame(0, 8'h50, 32'h0000_3000, 4, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) send_byte(tx_q[k]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid.rx_ready",    32'(rx_ready),    32'd1);
        chk("rst_mid.frame_valid", 32'(frame_valid), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_mid.no_pulse", 32'((n_crc - c0) + (n_len - l0) + (n_to - t0)), 32'd0);
        $display("frame rst_mid: reset after 2 data bytes");
        build_frame(0, 8'h51, 32'h0000_3004, 4, 1'b0, 1'b0, 1'b0);
        run_frame("after_rst");

        for (int n = 0; n < 24; n++) begin
            mode = $urandom_range(0, 9);
            len  = $urandom_range(0, MAXP);
            if (mode == 0) begin
                build_frame($urandom_range(0, 3), 8'($urandom), $urandom, $urandom_range(MAXP + 1, 255),
                            1'b0, 1'b0, 1'b1);
            end else begin
                build_frame($urandom_range(0, 3), 8'($urandom), $urandom, len, 1'b0, mode < 3, 1'b0);
            end
            run_frame($sformatf("rand%0d", n));
        end

        chk("pulse_overlap", 32'(n_multi), 32'd0);
        chk("pulse_width",   32'(n_wide),  32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
